// File: rtl/sal_axi_wr_resp.sv
// rtl/sal_axi_wr_resp.sv - AXI write responder: one INCR burst -> per-beat requests + one B response
// Optional statistics counters enabled by SAL_WR_RESP_STATS_EN.
module sal_axi_wr_resp #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 128,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ID_WIDTH-1:0]     awid,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic [LEN_WIDTH-1:0]    awlen,
   input  logic [2:0]              awsize,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wlast,
   output logic                    bvalid,
   input  logic                    bready,
   output logic [ID_WIDTH-1:0]     bid,
   output logic [1:0]              bresp,
   output logic                    req_valid,
   input  logic                    req_ready,
   output logic [ADDR_WIDTH-1:0]   req_addr,
   output logic [DATA_WIDTH-1:0]   req_data,
   output logic [DATA_WIDTH/8-1:0] req_strb,
   output logic                    req_last,
   output logic [15:0]             stat_burst_cnt,
   output logic [15:0]             stat_err_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DATA = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]            state_q,    state_d;
   logic                  awready_q,  awready_d;
   logic                  bvalid_q,   bvalid_d;
   logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
   logic [ID_WIDTH-1:0]   id_q,       id_d;
   logic [LEN_WIDTH-1:0]  len_q,      len_d;
   logic [2:0]            size_q,     size_d;
   logic                  err_q,      err_d;

   logic                  in_data;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  beat_is_last;
   logic [ADDR_WIDTH-1:0] size_bytes;

   assign in_data      = (state_q == ST_DATA);
   assign aw_hs        = awvalid & awready_q;
   assign wready       = in_data & req_ready;
   assign w_hs         = wvalid & wready;
   assign b_hs         = bvalid_q & bready;
   assign beat_is_last = (beat_cnt_q == len_q);
   assign size_bytes   = ADDR_WIDTH'(1) << size_q;

   assign awready   = awready_q;
   assign bvalid    = bvalid_q;
   assign bid       = id_q;
   assign bresp     = {err_q, 1'b0};
   assign req_valid = in_data & wvalid;
   assign req_addr  = addr_q;
   assign req_data  = wdata;
   assign req_strb  = wstrb;
   assign req_last  = wlast | beat_is_last;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      addr_d     = addr_q;
      id_d       = id_q;
      len_d      = len_q;
      size_d     = size_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            if (aw_hs) begin
               id_d       = awid;
               addr_d     = awaddr;
               len_d      = awlen;
               size_d     = awsize;
               beat_cnt_d = '0;
               err_d      = 1'b0;
               state_d    = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_hs) begin
               beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
               // Next beat aligns down to the transfer size before stepping.
               addr_d     = (addr_q & ~(size_bytes - ADDR_WIDTH'(1))) + size_bytes;
               if (wlast | beat_is_last) begin
                  err_d   = wlast ^ beat_is_last;
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (b_hs) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      awready_d = (state_d == ST_IDLE);
      bvalid_d  = (state_d == ST_RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         awready_q  <= 1'b0;
         bvalid_q   <= 1'b0;
         beat_cnt_q <= '0;
         addr_q     <= '0;
         id_q       <= '0;
         len_q      <= '0;
         size_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         awready_q  <= awready_d;
         bvalid_q   <= bvalid_d;
         beat_cnt_q <= beat_cnt_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         len_q      <= len_d;
         size_q     <= size_d;
         err_q      <= err_d;
      end
   end

`ifdef SAL_WR_RESP_STATS_EN
   logic [15:0] burst_cnt_q, burst_cnt_d;
   logic [15:0] err_cnt_q,   err_cnt_d;

   always_comb begin
      burst_cnt_d = burst_cnt_q;
      err_cnt_d   = err_cnt_q;
      if (b_hs) begin
         if (burst_cnt_q != 16'hFFFF) burst_cnt_d = burst_cnt_q + 16'd1;
         if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         burst_cnt_q <= burst_cnt_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign stat_burst_cnt = burst_cnt_q;
   assign stat_err_cnt   = err_cnt_q;
`else
   assign stat_burst_cnt = 16'd0;
   assign stat_err_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_sal_axi_wr_resp.sv
// tb/tb_sal_axi_wr_resp.sv - directed self-checking bench for sal_axi_wr_resp
module tb_sal_axi_wr_resp;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         awvalid, awready;
   logic [3:0]   awid;
   logic [31:0]  awaddr;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic         wvalid, wready;
   logic [127:0] wdata;
   logic [15:0]  wstrb;
   logic         wlast;
   logic         bvalid, bready;
   logic [3:0]   bid;
   logic [1:0]   bresp;
   logic         req_valid, req_ready;
   logic [31:0]  req_addr;
   logic [127:0] req_data;
   logic [15:0]  req_strb;
   logic         req_last;
   logic [15:0]  stat_burst_cnt, stat_err_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sal_axi_wr_resp dut (
      .clk(clk), .rst_n(rst_n),
      .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
      .awlen(awlen), .awsize(awsize),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_data(req_data), .req_strb(req_strb), .req_last(req_last),
      .stat_burst_cnt(stat_burst_cnt), .stat_err_cnt(stat_err_cnt)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size);
      int n = 0;
      awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size;
      while (awready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("aw_ready", awready, 1'b1);
      @(posedge clk); #1;
      awvalid = 1'b0;
      check("aw_drop", awready, 1'b0);
   endtask

   task automatic send_w(input logic [127:0] data, input logic last,
                         input logic [31:0] exp_addr, input logic exp_last);
      wvalid = 1'b1; wdata = data; wstrb = data[15:0]; wlast = last;
      #1;
      check("req_valid", req_valid, 1'b1);
      check("wready", wready, 1'b1);
      check("req_addr", req_addr, exp_addr);
      check("req_last", req_last, exp_last);
      check("req_data", req_data, data);
      check("req_strb", req_strb, data[15:0]);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
   endtask

   task automatic take_b(input logic [3:0] id, input logic [1:0] resp);
      check("bvalid", bvalid, 1'b1);
      check("bid", bid, id);
      check("bresp", bresp, resp);
      check("aw_in_resp", awready, 1'b0);
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      check("bvalid_clr", bvalid, 1'b0);
      check("aw_after_b", awready, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0; req_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_awready", awready, 1'b0);
      check("rst_bvalid", bvalid, 1'b0);
      check("rst_bid", bid, 4'h0);
      check("rst_bresp", bresp, 2'b00);
      check("rst_stat_burst", stat_burst_cnt, 16'h0);
      check("rst_stat_err", stat_err_cnt, 16'h0);
      rst_n = 1'b1;
      check("rel_awready_0", awready, 1'b0);
      @(posedge clk); #1;
      check("rel_awready_1", awready, 1'b1);
      wvalid = 1'b1;
      check("idle_wready", wready, 1'b0);
      wvalid = 1'b0;

      // Aligned two-beat burst
      send_aw(4'h0, 32'h0, 8'd1, 3'd4);
      send_w(128'h1111, 1'b0, 32'h0, 1'b0);
      send_w(128'h2222, 1'b1, 32'h10, 1'b1);
      take_b(4'h0, 2'b00);

      // Unaligned start
      send_aw(4'h5, 32'h4, 8'd2, 3'd4);
      send_w(128'h3333, 1'b0, 32'h4, 1'b0);
      send_w(128'h4444, 1'b0, 32'h10, 1'b0);
      send_w(128'h5555, 1'b1, 32'h20, 1'b1);
      take_b(4'h5, 2'b00);

      // Early wlast
      send_aw(4'h3, 32'h100, 8'd3, 3'd4);
      send_w(128'h6666, 1'b0, 32'h100, 1'b0);
      send_w(128'h7777, 1'b1, 32'h110, 1'b1);
      take_b(4'h3, 2'b10);

      // Missing wlast
      send_aw(4'h7, 32'h40, 8'd1, 3'd4);
      send_w(128'h8888, 1'b0, 32'h40, 1'b0);
      send_w(128'h9999, 1'b0, 32'h50, 1'b1);
      take_b(4'h7, 2'b10);

      // Scheduler backpressure then B backpressure
      send_aw(4'h2, 32'h202, 8'd1, 3'd2);
      send_w(128'hAAAA, 1'b0, 32'h202, 1'b0);
      req_ready = 1'b0;
      wvalid = 1'b1; wdata = 128'hBBBB; wstrb = 16'hBBBB; wlast = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("stall_wready", wready, 1'b0);
         check("stall_req_valid", req_valid, 1'b1);
         check("stall_addr", req_addr, 32'h204);
         @(posedge clk); #1;
      end
      wvalid = 1'b0; wlast = 1'b0;
      req_ready = 1'b1;
      send_w(128'hBBBB, 1'b1, 32'h204, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("hold_bvalid", bvalid, 1'b1);
         check("hold_bid", bid, 4'h2);
         check("hold_bresp", bresp, 2'b00);
         check("hold_awready", awready, 1'b0);
         @(posedge clk); #1;
      end
      take_b(4'h2, 2'b00);

      // Single-beat burst
      send_aw(4'h9, 32'h30, 8'd0, 3'd4);
      send_w(128'hCCCC, 1'b1, 32'h30, 1'b1);
      take_b(4'h9, 2'b00);

      // Reset mid-burst
      send_aw(4'h1, 32'h0, 8'd3, 3'd4);
      send_w(128'hDDDD, 1'b0, 32'h0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("mid_rst_bvalid", bvalid, 1'b0);
      check("mid_rst_awready", awready, 1'b0);
      check("mid_rst_wready", wready, 1'b0);
      check("mid_rst_stat_burst", stat_burst_cnt, 16'h0);
      check("mid_rst_stat_err", stat_err_cnt, 16'h0);
      @(posedge clk); #1;
      check("mid_rst_awready_hold", awready, 1'b0);
      rst_n = 1'b1;
      check("mid_rel_awready_0", awready, 1'b0);
      @(posedge clk); #1;
      check("mid_rel_awready_1", awready, 1'b1);
      check("mid_rel_bvalid", bvalid, 1'b0);

      // Erroneous burst after reset for the statistics path
      send_aw(4'h4, 32'h80, 8'd1, 3'd4);
      send_w(128'hEEEE, 1'b0, 32'h80, 1'b0);
      send_w(128'hFFFF, 1'b0, 32'h90, 1'b1);
      take_b(4'h4, 2'b10);
`ifdef SAL_WR_RESP_STATS_EN
      check("stat_burst", stat_burst_cnt, 16'd1);
      check("stat_err", stat_err_cnt, 16'd1);
`else
      check("stat_burst_off", stat_burst_cnt, 16'd0);
      check("stat_err_off", stat_err_cnt, 16'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sal_axi_wr_resp.md
Name: sal_axi_wr_resp

Overview:
AXI write-channel responder inside the SAL DDR controller, sitting behind the AW/W/B ports that bench masters drive. Accepts one INCR burst at a time (AW, then W beats), splits it into per-beat write requests with computed beat addresses toward the scheduler, and returns one B response per burst. Checks WLAST against AWLEN and flags protocol errors as SLVERR.

Parameters:
ID_WIDTH, 4, AXI ID width
ADDR_WIDTH, 32, AXI/request address width
DATA_WIDTH, 128, AXI data width (STRB = DATA_WIDTH/8)
LEN_WIDTH, 8, AWLEN width (beats = len+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awvalid  in  1  AW valid
awready  out  1  AW ready
awid  in  ID_WIDTH  burst ID
awaddr  in  ADDR_WIDTH  start address
awlen  in  LEN_WIDTH  beats-1
awsize  in  3  log2 bytes per beat (<= log2(DATA_WIDTH/8))
wvalid  in  1  W valid
wready  out  1  W ready
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wlast  in  1  last beat marker
bvalid  out  1  B valid
bready  in  1  B ready
bid  out  ID_WIDTH  response ID
bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
req_valid  out  1  per-beat write request valid
req_ready  in  1  scheduler accepts request
req_addr  out  ADDR_WIDTH  beat address
req_data  out  DATA_WIDTH  beat data
req_strb  out  DATA_WIDTH/8  beat strobes
req_last  out  1  final beat of burst
stat_burst_cnt  out  16  completed bursts (optional feature)
stat_err_cnt  out  16  SLVERR bursts (optional feature)

Behaviour:
- Reset: state IDLE; awready 0, bvalid 0, bid 0, bresp 0, beat counter 0, address/ID/len registers 0, err flag 0. awready is registered; rises the first clk after rst_n deasserts.
- FSM IDLE -> DATA -> RESP -> IDLE.
- IDLE: awready=1. On awvalid&awready: latch awid, awaddr, awlen, awsize; beat_cnt=0; err=0; awready drops next cycle; go DATA.
- DATA: req_valid = wvalid; wready = req_ready (combinational pass-through, zero latency); req_data/req_strb = wdata/wstrb; req_addr = current beat address register; req_last = wlast | (beat_cnt==len).
- Beat address: beat 0 = awaddr as given (unaligned allowed); beat n+1 = (addr_n & ~(2^size-1)) + 2^size; ADDR_WIDTH modular wrap, no 4KB check.
- On W handshake (wvalid&wready): beat_cnt++. If wlast && beat_cnt!=len -> err=1, burst ends. If beat_cnt==len && !wlast -> err=1, burst ends. Burst ending -> RESP next cycle.
- W not accepted outside DATA (wready=0); AW not accepted outside IDLE.
- RESP: bvalid=1, bid=latched ID, bresp = err ? 2'b10 : 2'b00; held stable until bready. On bvalid&bready -> IDLE; awready=1 the following cycle (no same-cycle AW bypass). Minimum burst turnaround: AW cycle + beats + 1 RESP cycle.
- awlen=0: single beat; wlast=1 on it -> OKAY.
- rst_n asserted mid-burst: immediate abort to reset values; no B issued for aborted burst.

Optional Feature:
SAL_WR_RESP_STATS_EN: when defined, stat_burst_cnt increments on every B handshake and stat_err_cnt on every B handshake with bresp=SLVERR; both 16-bit, saturate at 16'hFFFF, reset to 0. When undefined, both ports tied to 0 and no counter flops are instantiated.

Test Plan:
- AW id=0 addr=0x0 len=1 size=4, two W beats (wlast on 2nd), req_ready=1 -> req_addr 0x0, 0x10; req_last on beat 2; B bid=0 bresp=00 one cycle after last beat.
- Unaligned AW addr=0x4 len=2 size=4 -> req_addr 0x4, 0x10, 0x20.
- AW len=3, wlast on beat 2 -> burst ends after 2 beats, bresp=10; next AW accepted after bready.
- AW len=1, no wlast on beat 2 -> burst ends at beat 2, bresp=10.
- req_ready low 5 cycles mid-burst with wvalid=1 -> wready=0, req_addr stable, beat_cnt frozen; bready held low 3 cycles -> bvalid/bid/bresp stable, awready=0 throughout.
- rst_n pulsed mid-burst -> bvalid=0, awready=0 during reset, awready=1 one cycle after release; with SAL_WR_RESP_STATS_EN, counters read 0 then 1/1 after an erroneous burst.
